uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//   UART transmit serializer; the stage directly upstream of the UART receiver.
//   Accepts one parallel word per handshake and drives a serial frame on TX_OUT:
//   start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).
//   CLK is the bit clock: one bit per CLK cycle, i.e. the receiver's clock / Prescale.
//   TX_OUT connects to the receiver's RX_IN.
// PARAMETERS
//   DATA_WIDTH  8  width of P_DATA and number of data bits per frame (>=2)
// PORTS
//   CLK         in   1           bit-rate clock, rising edge
//   RST         in   1           asynchronous, active-low reset
//   P_DATA      in   DATA_WIDTH  word to transmit
//   DATA_VALID  in   1           request; accepted only when Busy=0 (IDLE)
//   PAR_EN      in   1           1 = insert parity bit after data
//   PAR_TYP     in   1           0 = even parity (^data), 1 = odd parity (~^data)
//   TX_OUT      out  1           serial line, idles high
//   Busy        out  1           high while a frame is in progress
// BEHAVIOUR
//   - Reset (RST=0, async): state=IDLE, TX_OUT=1, Busy=0, bit counter=0,
//     data/config registers cleared. Reset mid-frame aborts the frame and
//     forces TX_OUT=1 at once. No partial frame resumes after release.
//   - All outputs are registered. TX_OUT and Busy are driven directly from flops.
//   - FSM states: IDLE -> START -> DATA -> (PARITY if PAR_EN latched) -> STOP -> IDLE.
//   - IDLE: TX_OUT=1, Busy=0. When DATA_VALID=1 at edge k, the block latches
//     P_DATA, PAR_EN and PAR_TYP. Parity is computed from the latched word at
//     this edge. From edge k: state=START, TX_OUT=0, Busy=1.
//   - DATA: edges k+1..k+DATA_WIDTH drive TX_OUT=data[0]..data[DATA_WIDTH-1].
//     The counter width is $clog2(DATA_WIDTH). It wraps to 0 when leaving DATA.
//   - PARITY: edge k+DATA_WIDTH+1 drives the latched parity bit.
//   - STOP: the next edge drives TX_OUT=1 for one cycle.
//     At the following edge: state=IDLE, Busy=0.
//   - Busy is high for exactly DATA_WIDTH+2 cycles (no parity) or DATA_WIDTH+3
//     cycles (parity). Consecutive frames are therefore separated by at least one
//     idle-high cycle.
//   - DATA_VALID while Busy=1 is ignored. The word is not queued, and P_DATA or
//     config changes mid-frame have no effect.
//   - DATA_VALID held high continuously: a new frame is accepted on the first
//     IDLE edge.
// TESTING
//   1. Reset check: RST=0 -> TX_OUT=1, Busy=0. Release; hold DATA_VALID=0 for
//      20 cycles -> TX_OUT stays 1.
//   2. P_DATA=0xBB, PAR_EN=1, PAR_TYP=0, 1-cycle DATA_VALID -> TX_OUT sequence
//      0,1,1,0,1,1,1,0,1,0,1; Busy high for 11 cycles; then TX_OUT=1, Busy=0.
//   3. Same word with PAR_TYP=1 -> parity bit=1. With PAR_EN=0 -> 10-bit frame
//      0,1,1,0,1,1,1,0,1,1; Busy high for 10 cycles.
//   4. Loopback: TX_OUT->receiver RX_IN, receiver CLK = CLK*Prescale, for
//      Prescale 8/16/32 x parity {off, even, odd}, data 0xBB, 0x00, 0xFF, 0xA5 ->
//      receiver data_valid pulses once per frame with P_DATA equal to the sent
//      word, par_err=0, stp_err=0.
//   5. Pulse DATA_VALID with 0x55 at cycle 4 of a 0xBB frame -> frame bits
//      unchanged; no second frame follows.
//   6. Assert RST at data bit 3 -> TX_OUT=1 and Busy=0 immediately. After
//      release, a new 0x3C request -> a clean, complete frame.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, DATA_WIDTH data bits LSB first,
// optional parity, stop bit; one bit per CLK cycle, all outputs registered.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state, state_next;
    logic [CW-1:0]           cnt, cnt_next;
    logic [DATA_WIDTH-1:0]   data_q, data_next;
    logic                    par_en_q, par_en_next;
    logic                    par_bit_q, par_bit_next;
    logic                    tx_q, tx_next;
    logic                    busy_q, busy_next;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            data_q    <= data_next;
            par_en_q  <= par_en_next;
            par_bit_q <= par_bit_next;
            tx_q      <= tx_next;
            busy_q    <= busy_next;
        end
    end

    // State names the bit currently on the line; the next-state logic
    // computes the level that the coming edge will register onto TX_OUT.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        data_next    = data_q;
        par_en_next  = par_en_q;
        par_bit_next = par_bit_q;
        tx_next      = tx_q;
        busy_next    = busy_q;

        unique case (state)
            IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
                cnt_next  = '0;
                if (DATA_VALID) begin
                    data_next    = P_DATA;
                    par_en_next  = PAR_EN;
                    par_bit_next = PAR_TYP ? ~^P_DATA : ^P_DATA;
                    state_next   = START;
                    tx_next      = 1'b0;
                    busy_next    = 1'b1;
                end
            end
            START: begin
                state_next = DATA;
                cnt_next   = '0;
                tx_next    = data_q[0];
            end
            DATA: begin
                if (cnt == LAST_BIT) begin
                    cnt_next = '0;
                    if (par_en_q) begin
                        state_next = PARITY;
                        tx_next    = par_bit_q;
                    end else begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                    tx_next  = data_q[cnt + 1'b1];
                end
            end
            PARITY: begin
                state_next = STOP;
                tx_next    = 1'b1;
            end
            STOP: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule
